mcs4_bus_master: RTL and testbench
==================================

MCS4_BUS_MASTER -- requirements
Module: mcs4_bus_master

Interface
REQ-001 Parameter CL_CYCLES, default 8: number of clk cycles cl_rom stays asserted after rst_n deasserts.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 sync  out  1  high during phase X3; ROMs restart their phase count on it.
REQ-005 cl_rom  out  1  ROM I/O clear.
REQ-006 cm_rom  out  1  ROM command strobe (I/O opcode at M2, chip select at X2).
REQ-007 dbus_out  out  mcs4::char_t  nibble driven to ROM dbus_in.
REQ-008 dbus_in  in  mcs4::char_t  OR of all ROM dbus_out nibbles.
REQ-009 cmd_valid, cmd_ready  in/out  1  command handshake; transfer when both high on a clk edge.
REQ-010 cmd_op  in  mcs4::bus_cmd_t  FETCH, SRC, WRR or RDR.
REQ-011 cmd_addr  in  12  ROM byte address {chip, hi, lo}; cmd_data  in  mcs4::char_t  chip id (SRC) or write data (WRR).
REQ-012 rsp_valid  out  1  one-cycle response pulse; rsp_data  out  mcs4::byte_t  fetched byte; rsp_io  out  mcs4::char_t  RDR result.

Function
REQ-013 Free-running 3-bit phase counter, cast to mcs4::instr_cyc_t: A1=0, A2, A3, M1, M2, X1, X2, X3=7; wraps X3->A1.
REQ-014 sync = (phase == X3), combinational from the phase register.
REQ-015 cmd_ready = (phase == X3) && !cl_rom; a command accepted on that edge executes in the following 8-cycle instruction cycle.
REQ-016 With no command accepted, the next cycle is idle: dbus_out = 0, cm_rom = 0 in every phase, and no rsp_valid.
REQ-017 Active cycle, dbus_out per phase: A1 = cmd_addr[3:0], A2 = cmd_addr[7:4], A3 = cmd_addr[11:8].
REQ-018 M1 and M2: dbus_out = 0 for FETCH and SRC; at M2 for WRR/RDR, dbus_out = mcs4::WRR / mcs4::RDR OPA code and cm_rom = 1.
REQ-019 X2: SRC drives dbus_out = cmd_data with cm_rom = 1; WRR drives dbus_out = cmd_data with cm_rom = 0; RDR drives 0.
REQ-020 All phases and cases not named in REQ-017..019: dbus_out = 0, cm_rom = 0.
REQ-021 Sampling: dbus_in registered on the M1 edge into rsp_data[7:4], on the M2 edge into rsp_data[3:0], and for RDR only on the X2 edge into rsp_io.
REQ-022 rsp_valid pulses high for exactly the X3 cycle of each active cycle, 8 clk after cmd acceptance; rsp_data/rsp_io hold until the next pulse.
REQ-023 rsp_io = 0 in responses to non-RDR commands.
REQ-024 No backpressure on rsp: the consumer must take it on the pulse.
REQ-025 Back-to-back commands (cmd_valid held high) produce one instruction cycle each with no idle gap.

Reset
REQ-026 While rst_n = 0: phase = X3, so sync = 1; cl_rom = 1; cmd_ready = 0; rsp_valid = 0; rsp_data = 0; rsp_io = 0; dbus_out = 0; cm_rom = 0; pending command cleared.
REQ-027 After deassertion, cl_rom stays high CL_CYCLES clk (counter), then drops; phase runs from the first edge.
REQ-028 Reset mid-cycle aborts the operation: no rsp_valid for it, and no partial write follows.

Structure
REQ-029 Package mcs4 holds char_t, byte_t, instr_cyc_t, ioram_opa_t (WRR, RDR codes) and the new bus_cmd_t enum.
REQ-030 Sub-module mcs4_timing_gen contains the phase counter and sync, reused by future masters.

Verification
REQ-031 Bench instantiates mcs4_bus_master with two i4001 (ROM_ID 0, 1; IO_MASK 4'b0011) and ORs their dbus_out.
REQ-032 Reset release -> cl_rom high for 8 clk, sync every 8th clk, cmd_ready first asserted coincident with sync after cl_rom drops.
REQ-033 FETCH addr 0x1A5, ROM1[0xA5] = 0x3C -> dbus_out 5, A, 1 in A1-A3; rsp_valid 8 clk later with rsp_data = 0x3C.
REQ-034 SRC data 1, then WRR data 0xF -> ROM1 io_out = 4'b1100, ROM0 io_out unchanged at 0.
REQ-035 SRC 1, then RDR with ROM1 io_in = 4'b0101 after the REQ-034 write -> rsp_io = 4'b1101.
REQ-036 Three back-to-back FETCHes -> three rsp_valid pulses 8 clk apart; rst_n pulsed low during the second -> no further rsp_valid, and outputs match REQ-026.

Source files
------------

// File: rtl/mcs4.sv
// Shared MCS-4 bus types: nibble/byte widths, instruction-cycle phases,
// ROM I/O opcodes and the bus-master command set.
package mcs4;

  typedef logic [3:0] char_t;
  typedef logic [7:0] byte_t;

  typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} instr_cyc_t;

  typedef enum logic [3:0] {WRR = 4'h2, RDR = 4'hA} ioram_opa_t;

  typedef enum logic [1:0] {CMD_FETCH, CMD_SRC, CMD_WRR, CMD_RDR} bus_cmd_t;

  typedef struct packed {
    bus_cmd_t    op;
    logic [11:0] addr;
    char_t       data;
  } bus_req_t;

  // OPA nibble a master drives at M2 for a ROM I/O command.
  function automatic char_t opa_code(bus_cmd_t op);
    return (op == CMD_RDR) ? char_t'(RDR) : char_t'(WRR);
  endfunction

endpackage

// File: rtl/i4001.sv
// Bus-functional 4001 ROM + 4-bit I/O port, programmable through a side
// write port so the mask contents can be loaded after elaboration.
module i4001
  import mcs4::*;
#(
  parameter char_t ROM_ID  = 4'd0,
  parameter char_t IO_MASK = 4'b0000  // 1 = input line, 0 = output line
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  sync,
  input  logic  cl,
  input  logic  cm,
  input  char_t dbus_in,
  output char_t dbus_out,
  input  char_t io_in,
  output char_t io_out,
  input  logic  prog_we,
  input  byte_t prog_addr,
  input  byte_t prog_data
);

  byte_t      mem [256];
  instr_cyc_t ph;
  byte_t      addr;
  logic       sel;
  logic       src_sel;
  logic       io_act;
  char_t      io_opa;

  always_ff @(posedge clk) begin
    if (prog_we) mem[prog_addr] <= prog_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ph <= X3;
    else        ph <= sync ? A1 : instr_cyc_t'(ph + 3'd1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
      sel  <= 1'b0;
    end else begin
      case (ph)
        A1:      addr[3:0] <= dbus_in;
        A2:      addr[7:4] <= dbus_in;
        A3:      sel       <= (dbus_in == ROM_ID);
        default: ;
      endcase
    end
  end

  // I/O command state: SRC latches the chip select, M2 with cm latches the
  // opcode, X2 performs the write; cl wipes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_sel <= 1'b0;
      io_act  <= 1'b0;
      io_opa  <= '0;
      io_out  <= '0;
    end else if (cl) begin
      src_sel <= 1'b0;
      io_act  <= 1'b0;
      io_opa  <= '0;
      io_out  <= '0;
    end else begin
      case (ph)
        M2: begin
          io_act <= cm && src_sel;
          io_opa <= dbus_in;
        end
        X2: begin
          if (cm) src_sel <= (dbus_in == ROM_ID);
          if (io_act && io_opa == char_t'(WRR)) io_out <= dbus_in & ~IO_MASK;
        end
        X3:      io_act <= 1'b0;
        default: ;
      endcase
    end
  end

  always_comb begin
    dbus_out = '0;
    case (ph)
      M1: if (sel) dbus_out = mem[addr][7:4];
      M2: if (sel) dbus_out = mem[addr][3:0];
      X2: if (io_act && io_opa == char_t'(RDR))
            dbus_out = (io_out & ~IO_MASK) | (io_in & IO_MASK);
      default: ;
    endcase
  end

endmodule

// File: rtl/mcs4_timing_gen.sv
// Free-running 8-phase instruction-cycle counter; sync marks X3 so that
// peripherals can realign their own phase counters.
module mcs4_timing_gen
  import mcs4::*;
(
  input  logic       clk,
  input  logic       rst_n,
  output instr_cyc_t phase,
  output logic       sync
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) phase <= X3;
    else        phase <= instr_cyc_t'(phase + 3'd1);
  end

  assign sync = (phase == X3);

endmodule

// File: rtl/mcs4_bus_master.sv
// MCS-4 bus master: turns one accepted command per instruction cycle into
// the A/M/X nibble sequence on the ROM bus and returns the sampled result.
module mcs4_bus_master
  import mcs4::*;
#(
  parameter int CL_CYCLES = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        sync,
  output logic        cl_rom,
  output logic        cm_rom,
  output char_t       dbus_out,
  input  char_t       dbus_in,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  bus_cmd_t    cmd_op,
  input  logic [11:0] cmd_addr,
  input  char_t       cmd_data,
  output logic        rsp_valid,
  output byte_t       rsp_data,
  output char_t       rsp_io
);

  localparam int CLW = (CL_CYCLES > 0) ? $clog2(CL_CYCLES + 1) : 1;

  instr_cyc_t     phase;
  logic [CLW-1:0] cl_cnt;
  logic           act;
  bus_req_t       req;
  byte_t          cap;
  logic           accept;

  mcs4_timing_gen u_timing (
    .clk   (clk),
    .rst_n (rst_n),
    .phase (phase),
    .sync  (sync)
  );

  // cl_rom is registered so it is high during reset even when CL_CYCLES = 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cl_cnt <= CLW'(CL_CYCLES);
      cl_rom <= 1'b1;
    end else begin
      if (cl_cnt != '0) cl_cnt <= cl_cnt - CLW'(1);
      cl_rom <= (cl_cnt > CLW'(1));
    end
  end

  assign cmd_ready = (phase == X3) && !cl_rom;
  assign accept    = cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act <= 1'b0;
      req <= '0;
    end else if (phase == X3) begin
      act <= accept;
      if (accept) req <= '{op: cmd_op, addr: cmd_addr, data: cmd_data};
    end
  end

  // Fetched nibbles collect in cap so rsp_data only changes on a pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap       <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_io    <= '0;
    end else begin
      rsp_valid <= act && (phase == X2);
      if (act) begin
        case (phase)
          M1: cap[7:4] <= dbus_in;
          M2: cap[3:0] <= dbus_in;
          X2: begin
            rsp_data <= cap;
            rsp_io   <= (req.op == CMD_RDR) ? dbus_in : '0;
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    dbus_out = '0;
    cm_rom   = 1'b0;
    if (act) begin
      case (phase)
        A1: dbus_out = req.addr[3:0];
        A2: dbus_out = req.addr[7:4];
        A3: dbus_out = req.addr[11:8];
        M2: begin
          if (req.op == CMD_WRR || req.op == CMD_RDR) begin
            dbus_out = opa_code(req.op);
            cm_rom   = 1'b1;
          end
        end
        X2: begin
          case (req.op)
            CMD_SRC: begin
              dbus_out = req.data;
              cm_rom   = 1'b1;
            end
            CMD_WRR: dbus_out = req.data;
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcs4_bus_master.sv
// Bench: bus master driving two 4001 ROMs; directed table, randomized
// commands against a transaction-level model, and reset corner cases.
module tb_mcs4_bus_master;
  import mcs4::*;

  localparam char_t MASK = 4'b0011;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sync, cl_rom, cm_rom;
  char_t       dbus_out, dbus_in, rom_dout0, rom_dout1;
  logic        cmd_valid, cmd_ready;
  bus_cmd_t    cmd_op;
  logic [11:0] cmd_addr;
  char_t       cmd_data;
  logic        rsp_valid;
  byte_t       rsp_data;
  char_t       rsp_io;
  char_t       io_in0, io_in1, io_out0, io_out1;
  logic        prog_we0, prog_we1;
  byte_t       prog_addr, prog_data;

  assign dbus_in = rom_dout0 | rom_dout1;

  always #5 clk = ~clk;

  mcs4_bus_master #(.CL_CYCLES(8)) dut (
    .clk(clk), .rst_n(rst_n), .sync(sync), .cl_rom(cl_rom), .cm_rom(cm_rom),
    .dbus_out(dbus_out), .dbus_in(dbus_in), .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_io(rsp_io)
  );

  i4001 #(.ROM_ID(4'd0), .IO_MASK(MASK)) u_rom0 (
    .clk(clk), .rst_n(rst_n), .sync(sync), .cl(cl_rom), .cm(cm_rom),
    .dbus_in(dbus_out), .dbus_out(rom_dout0), .io_in(io_in0), .io_out(io_out0),
    .prog_we(prog_we0), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  i4001 #(.ROM_ID(4'd1), .IO_MASK(MASK)) u_rom1 (
    .clk(clk), .rst_n(rst_n), .sync(sync), .cl(cl_rom), .cm(cm_rom),
    .dbus_in(dbus_out), .dbus_out(rom_dout1), .io_in(io_in1), .io_out(io_out1),
    .prog_we(prog_we1), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  int    checks = 0;
  int    errors = 0;
  byte_t romimg [2][256];
  char_t io_m [2];
  int    src_m;
  byte_t last_data;
  char_t last_io;

  typedef struct {
    bus_cmd_t    op;
    logic [11:0] addr;
    char_t       data;
    char_t       io0;
    char_t       io1;
    bit          hold;
    byte_t       xd;
    char_t       xio;
  } vec_t;

  vec_t tbl [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected {cm_rom, dbus_out} for each phase of an active cycle.
  function automatic logic [4:0] exp_bus(bus_cmd_t op, logic [11:0] a, char_t d, int p);
    logic [4:0] e [8];
    for (int i = 0; i < 8; i++) e[i] = 5'h0;
    e[0] = {1'b0, a[3:0]};
    e[1] = {1'b0, a[7:4]};
    e[2] = {1'b0, a[11:8]};
    if (op == CMD_WRR) e[4] = {1'b1, 4'h2};
    if (op == CMD_RDR) e[4] = {1'b1, 4'hA};
    if (op == CMD_SRC) e[6] = {1'b1, d};
    if (op == CMD_WRR) e[6] = {1'b0, d};
    return e[p];
  endfunction

  function automatic byte_t model_byte(logic [11:0] a);
    if (a[11:8] == 4'd0) return romimg[0][a[7:0]];
    if (a[11:8] == 4'd1) return romimg[1][a[7:0]];
    return 8'h00;
  endfunction

  function automatic char_t model_io(bus_cmd_t op);
    char_t iin;
    if (op != CMD_RDR || src_m < 0 || src_m > 1) return 4'h0;
    iin = (src_m == 0) ? io_in0 : io_in1;
    return (io_m[src_m] & ~MASK) | (iin & MASK);
  endfunction

  task automatic model_apply(bus_cmd_t op, char_t d);
    if (op == CMD_SRC) src_m = int'(d);
    if (op == CMD_WRR && src_m >= 0 && src_m < 2) io_m[src_m] = d & ~MASK;
  endtask

  task automatic model_reset();
    io_m[0] = 4'h0; io_m[1] = 4'h0; src_m = -1;
    last_data = 8'h00; last_io = 4'h0;
  endtask

  // Called on a negedge in phase X3; returns on the X3 negedge of the cycle.
  task automatic exec(bus_cmd_t op, logic [11:0] a, char_t d, byte_t xd, char_t xio);
    logic [4:0] e;
    chk("ready_at_issue", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = a; cmd_data = d;
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      if (p == 0) begin
        cmd_valid = 1'b0;
        cmd_addr  = 12'($urandom);
        cmd_data  = 4'($urandom);
        cmd_op    = bus_cmd_t'(2'($urandom));
      end
      e = exp_bus(op, a, d, p);
      chk($sformatf("dbus_out_p%0d", p), dbus_out, e[3:0]);
      chk($sformatf("cm_rom_p%0d", p), cm_rom, e[4]);
      chk($sformatf("rsp_valid_p%0d", p), rsp_valid, p == 7);
      chk($sformatf("sync_p%0d", p), sync, p == 7);
      chk($sformatf("cmd_ready_p%0d", p), cmd_ready, p == 7);
    end
    chk("rsp_data", rsp_data, xd);
    chk("rsp_io", rsp_io, xio);
    last_data = xd; last_io = xio;
    model_apply(op, d);
    chk("io_out0", io_out0, io_m[0]);
    chk("io_out1", io_out1, io_m[1]);
  endtask

  task automatic idle_cycle();
    for (int p = 0; p < 8; p++) begin
      @(negedge clk);
      chk("idle_dbus", dbus_out, 0);
      chk("idle_cm", cm_rom, 0);
      chk("idle_rsp_valid", rsp_valid, 0);
      chk("idle_rsp_hold", {rsp_io, rsp_data}, {last_io, last_data});
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_sync", sync, 1);
    chk("rst_cl_rom", cl_rom, 1);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_io", rsp_io, 0);
    chk("rst_dbus", dbus_out, 0);
    chk("rst_cm", cm_rom, 0);
  endtask

  // Release at a negedge; k counts posedges since release.
  task automatic release_reset();
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      chk($sformatf("cl_rom_k%0d", k), cl_rom, k < 8);
      chk($sformatf("sync_k%0d", k), sync, (k % 8) == 0);
      chk($sformatf("cmd_ready_k%0d", k), cmd_ready, (k % 8) == 0 && k >= 8);
      chk($sformatf("no_rsp_k%0d", k), rsp_valid, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_cmd_t    op;
    logic [11:0] a;
    char_t       d;

    cmd_valid = 1'b0; cmd_op = CMD_FETCH; cmd_addr = '0; cmd_data = '0;
    io_in0 = '0; io_in1 = '0;
    prog_we0 = 1'b0; prog_we1 = 1'b0; prog_addr = '0; prog_data = '0;
    model_reset();

    @(negedge clk);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) begin
        romimg[r][i] = (r == 1 && i == 8'hA5) ? 8'h3C : 8'($urandom);
        prog_we0 = (r == 0); prog_we1 = (r == 1);
        prog_addr = 8'(i); prog_data = romimg[r][i];
        @(negedge clk);
      end
    end
    prog_we0 = 1'b0; prog_we1 = 1'b0;

    chk_reset_outputs();
    release_reset();

    tbl[0]  = '{CMD_FETCH, 12'h1A5, 4'h0, 4'h0, 4'h0, 1'b1, 8'h3C, 4'h0};
    tbl[1]  = '{CMD_SRC,   12'h000, 4'h1, 4'h0, 4'h0, 1'b0, romimg[0][8'h00], 4'h0};
    tbl[2]  = '{CMD_WRR,   12'h100, 4'hF, 4'h0, 4'h0, 1'b1, romimg[1][8'h00], 4'h0};
    tbl[3]  = '{CMD_SRC,   12'h2FF, 4'h1, 4'h0, 4'h0, 1'b1, 8'h00, 4'h0};
    tbl[4]  = '{CMD_RDR,   12'h0A5, 4'h0, 4'h0, 4'h5, 1'b1, romimg[0][8'hA5], 4'hD};
    tbl[5]  = '{CMD_SRC,   12'h1FE, 4'h0, 4'h0, 4'h0, 1'b0, romimg[1][8'hFE], 4'h0};
    tbl[6]  = '{CMD_RDR,   12'h300, 4'h0, 4'hA, 4'h0, 1'b1, 8'h00, 4'h2};
    tbl[7]  = '{CMD_WRR,   12'h0C3, 4'h6, 4'h0, 4'h0, 1'b1, romimg[0][8'hC3], 4'h0};
    tbl[8]  = '{CMD_RDR,   12'h001, 4'h0, 4'hF, 4'h0, 1'b1, romimg[0][8'h01], 4'h7};
    tbl[9]  = '{CMD_FETCH, 12'h1A5, 4'h0, 4'h0, 4'h0, 1'b1, 8'h3C, 4'h0};
    tbl[10] = '{CMD_FETCH, 12'h0FF, 4'h0, 4'h0, 4'h0, 1'b1, romimg[0][8'hFF], 4'h0};
    tbl[11] = '{CMD_FETCH, 12'h1FF, 4'h0, 4'h0, 4'h0, 1'b0, romimg[1][8'hFF], 4'h0};
    tbl[12] = '{CMD_SRC,   12'h200, 4'h5, 4'h0, 4'h0, 1'b1, 8'h00, 4'h0};
    tbl[13] = '{CMD_RDR,   12'h1A5, 4'h0, 4'hF, 4'hF, 1'b1, 8'h3C, 4'h0};
    tbl[14] = '{CMD_WRR,   12'h000, 4'hF, 4'h0, 4'h0, 1'b0, romimg[0][8'h00], 4'h0};

    for (int i = 0; i < 15; i++) begin
      io_in0 = tbl[i].io0; io_in1 = tbl[i].io1;
      exec(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].xd, tbl[i].xio);
      if (!tbl[i].hold) idle_cycle();
    end
    chk("rom1_io_after_wrr", io_out1, 4'b1100);
    chk("rom0_io_after_wrr", io_out0, 4'b0100);

    for (int n = 0; n < 40; n++) begin
      op = bus_cmd_t'(2'($urandom));
      a  = {4'($urandom_range(0, 2)), 8'($urandom)};
      d  = (op == CMD_SRC) ? 4'($urandom_range(0, 2)) : 4'($urandom);
      io_in0 = 4'($urandom); io_in1 = 4'($urandom);
      exec(op, a, d, model_byte(a), model_io(op));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    // Reset in the A3 phase of a back-to-back FETCH: no response may follow.
    exec(CMD_FETCH, 12'h1A5, 4'h0, 8'h3C, 4'h0);
    cmd_valid = 1'b1; cmd_op = CMD_FETCH; cmd_addr = 12'h0FF; cmd_data = 4'h0;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    chk_reset_outputs();
    chk("rst_io_out0", io_out0, 0);
    chk("rst_io_out1", io_out1, 0);
    @(negedge clk);
    release_reset();
    exec(CMD_FETCH, 12'h1A5, 4'h0, 8'h3C, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
